// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and defaults for the alarm annunciator
// Encodings are shared with the alarm FSM and top-level glue.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SOUNDING  = 2'b01,
        ESCALATED = 2'b10,
        SILENCED  = 2'b11
    } ann_state_e;

    localparam logic [3:0] DEFAULT_CODE = 4'hA;
    localparam logic [1:0] BAD_MAX      = 2'd3;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == BAD_MAX) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// rtl/alarm_tick_gen.sv - prescaler producing a single-cycle tick every CLK_DIV cycles
// Held at zero while disabled; clr_i restarts the period on the next edge.
module alarm_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (int'(cnt_q) == CLK_DIV - 1);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - turns the alarm level into pulsed siren/strobe with escalation and disarm
// All outputs are registered; every counter restarts whenever the state changes.
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int         CLK_DIV        = 16,
    parameter int         BEEP_ON        = 4,
    parameter int         BEEP_OFF       = 4,
    parameter int         ESCALATE_TICKS = 64,
    parameter int         SNOOZE_TICKS   = 32,
    parameter logic [3:0] CODE           = DEFAULT_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_in,
    input  logic [3:0] code_in,
    input  logic       code_valid,
    output logic       siren,
    output logic       strobe,
    output logic       escalated,
    output logic       silenced,
    output logic [1:0] ann_state,
    output logic [1:0] bad_cnt
);

    localparam int PH_W  = $clog2(BEEP_ON + BEEP_OFF + 1);
    localparam int ESC_W = $clog2(ESCALATE_TICKS + 1);
    localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);

    ann_state_e       state_q, state_d;
    logic [1:0]       bad_q, bad_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [ESC_W-1:0] esc_q, esc_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             strobe_q, strobe_d;
    logic             siren_q, siren_d;
    logic             escalated_q, silenced_q;

    logic tick;
    logic code_hit, code_miss;
    logic armed;
    logic state_chg;

    alarm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    assign code_hit  = code_valid && (code_in == CODE);
    assign code_miss = code_valid && (code_in != CODE);
    assign armed     = (state_q == SOUNDING) || (state_q == ESCALATED);
    assign state_chg = (state_d != state_q);

    // Precedence: alarm drop, correct code, third bad code, then timeouts.
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (alarm_in) state_d = SOUNDING;
            end
            SOUNDING, ESCALATED: begin
                if (!alarm_in) begin
                    state_d = IDLE;
                end else if (code_hit) begin
                    state_d = SILENCED;
                    bad_d   = '0;
                end else begin
                    if (code_miss) bad_d = sat_inc2(bad_q);
                    if ((state_q == SOUNDING) &&
                        ((code_miss && bad_d == BAD_MAX) ||
                         (tick && int'(esc_q) == ESCALATE_TICKS - 1))) begin
                        state_d = ESCALATED;
                    end
                end
            end
            SILENCED: begin
                if (!alarm_in) begin
                    state_d = IDLE;
                end else if (tick && int'(snz_q) == SNOOZE_TICKS - 1) begin
                    state_d = SOUNDING;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) bad_d = '0;
    end

    always_comb begin
        phase_d  = phase_q;
        esc_d    = esc_q;
        snz_d    = snz_q;
        strobe_d = strobe_q;
        if (state_chg) begin
            phase_d  = '0;
            esc_d    = '0;
            snz_d    = '0;
            strobe_d = 1'b0;
        end else if (tick) begin
            if (armed) begin
                phase_d  = (int'(phase_q) == BEEP_ON + BEEP_OFF - 1) ? '0 : phase_q + 1'b1;
                strobe_d = ~strobe_q;
            end
            if (state_q == SOUNDING) esc_d = esc_q + 1'b1;
            if (state_q == SILENCED) snz_d = snz_q + 1'b1;
        end
    end

    always_comb begin
        siren_d = 1'b0;
        if (state_d == ESCALATED) begin
            siren_d = 1'b1;
        end else if (state_d == SOUNDING) begin
            siren_d = (int'(phase_d) < BEEP_ON);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bad_q       <= '0;
            phase_q     <= '0;
            esc_q       <= '0;
            snz_q       <= '0;
            strobe_q    <= 1'b0;
            siren_q     <= 1'b0;
            escalated_q <= 1'b0;
            silenced_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bad_q       <= bad_d;
            phase_q     <= phase_d;
            esc_q       <= esc_d;
            snz_q       <= snz_d;
            strobe_q    <= strobe_d;
            siren_q     <= siren_d;
            escalated_q <= (state_d == ESCALATED);
            silenced_q  <= (state_d == SILENCED);
        end
    end

    assign siren     = siren_q;
    assign strobe    = strobe_q;
    assign escalated = escalated_q;
    assign silenced  = silenced_q;
    assign ann_state = state_q;
    assign bad_cnt   = bad_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb/tb_alarm_annunciator.sv - directed and randomized checks of alarm_annunciator
// The reference model tracks only state, cycles since entry and the bad-code count.
module tb_alarm_annunciator;

    localparam int         CLK_DIV  = 2;
    localparam int         BEEP_ON  = 2;
    localparam int         BEEP_OFF = 2;
    localparam int         ESC      = 8;
    localparam int         SNZ      = 4;
    localparam logic [3:0] CODE     = 4'hA;

    logic       clk = 1'b0;
    logic       rst;
    logic       alarm_in;
    logic [3:0] code_in;
    logic       code_valid;
    logic       siren, strobe, escalated, silenced;
    logic [1:0] ann_state, bad_cnt;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_state = 0;
    int m_cyc   = 0;
    int m_bad   = 0;

    alarm_annunciator #(
        .CLK_DIV        (CLK_DIV),
        .BEEP_ON        (BEEP_ON),
        .BEEP_OFF       (BEEP_OFF),
        .ESCALATE_TICKS (ESC),
        .SNOOZE_TICKS   (SNZ),
        .CODE           (CODE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alarm_in   (alarm_in),
        .code_in    (code_in),
        .code_valid (code_valid),
        .siren      (siren),
        .strobe     (strobe),
        .escalated  (escalated),
        .silenced   (silenced),
        .ann_state  (ann_state),
        .bad_cnt    (bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cyc   = 0;
        m_bad   = 0;
    endtask

    task automatic model_edge(input logic a, input logic cv, input logic [3:0] c);
        int  ns, nb;
        bit  hit, miss;
        ns   = m_state;
        nb   = m_bad;
        hit  = cv && (c == CODE);
        miss = cv && (c != CODE);
        case (m_state)
            0: if (a) ns = 1;
            1, 2: begin
                if (!a) ns = 0;
                else if (hit) begin
                    ns = 3;
                    nb = 0;
                end else begin
                    if (miss && nb < 3) nb = nb + 1;
                    if (m_state == 1 && ((miss && nb == 3) || (m_cyc + 1 == CLK_DIV * ESC))) ns = 2;
                end
            end
            default: begin
                if (!a) ns = 0;
                else if (m_cyc + 1 == CLK_DIV * SNZ) ns = 1;
            end
        endcase
        if (ns == 0) nb = 0;
        m_cyc   = (ns != m_state) ? 0 : m_cyc + 1;
        m_state = ns;
        m_bad   = nb;
    endtask

    task automatic check_model();
        logic exp_siren, exp_strobe;
        int   ticks;
        ticks      = m_cyc / CLK_DIV;
        exp_siren  = (m_state == 2) || (m_state == 1 && (ticks % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
        exp_strobe = (m_state == 1 || m_state == 2) && (ticks % 2 == 1);
        chk("state",     8'(ann_state), 8'(m_state));
        chk("siren",     8'(siren),     8'(exp_siren));
        chk("strobe",    8'(strobe),    8'(exp_strobe));
        chk("escalated", 8'(escalated), 8'(m_state == 2));
        chk("silenced",  8'(silenced),  8'(m_state == 3));
        chk("bad_cnt",   8'(bad_cnt),   8'(m_bad));
    endtask

    task automatic step(input logic a, input logic cv, input logic [3:0] c);
        alarm_in   = a;
        code_valid = cv;
        code_in    = c;
        @(posedge clk);
        model_edge(a, cv, c);
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] siren_pat;
        int         guard;
        rst        = 1'b1;
        alarm_in   = 1'b0;
        code_valid = 1'b0;
        code_in    = 4'h0;
        siren_pat  = 8'b0000_1111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 8'(ann_state), 8'h00);
        chk("reset_siren", 8'(siren), 8'h00);
        rst = 1'b0;
        model_reset();

        repeat (50) step(1'b0, 1'b0, 4'h0);

        // Asynchronous reset landing between edges while sounding.
        repeat (5) step(1'b1, 1'b0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state",  8'(ann_state), 8'h00);
        chk("async_rst_siren",  8'(siren),     8'h00);
        chk("async_rst_strobe", 8'(strobe),    8'h00);
        alarm_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        step(1'b1, 1'b0, 4'h0);
        chk("enter_sounding", 8'(ann_state), 8'h01);
        for (int i = 0; i < 16; i++) begin
            chk("siren_pattern", 8'(siren), 8'(siren_pat[i % 8]));
            chk("strobe_pattern", 8'(strobe), 8'((i / 2) % 2));
            step(1'b1, 1'b0, 4'h0);
        end
        chk("escalate_16", 8'(ann_state), 8'h02);
        chk("escalate_siren", 8'(siren), 8'h01);
        step(1'b0, 1'b0, 4'h0);

        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h3);
        chk("bad1", 8'(bad_cnt), 8'h01);
        step(1'b1, 1'b1, 4'h3);
        chk("bad2", 8'(bad_cnt), 8'h02);
        step(1'b1, 1'b1, 4'h3);
        chk("bad3", 8'(bad_cnt), 8'h03);
        chk("bad3_escalated", 8'(ann_state), 8'h02);
        step(1'b1, 1'b1, 4'hA);
        chk("good_state", 8'(ann_state), 8'h03);
        chk("good_silenced", 8'(silenced), 8'h01);
        chk("good_siren", 8'(siren), 8'h00);
        chk("good_bad", 8'(bad_cnt), 8'h00);

        step(1'b1, 1'b1, 4'h3);
        chk("silenced_ignores_code", 8'(ann_state), 8'h03);
        repeat (6) step(1'b1, 1'b0, 4'h0);
        chk("snooze_7", 8'(ann_state), 8'h03);
        step(1'b1, 1'b0, 4'h0);
        chk("snooze_8", 8'(ann_state), 8'h01);
        repeat (16) step(1'b1, 1'b0, 4'h0);
        chk("re_escalate", 8'(ann_state), 8'h02);
        step(1'b1, 1'b1, 4'hA);
        repeat (3) step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        chk("silenced_drop", 8'(ann_state), 8'h00);

        step(1'b1, 1'b0, 4'h0);
        guard = 0;
        while (m_cyc != CLK_DIV * ESC - 1 && guard < 100) begin
            step(1'b1, 1'b0, 4'h0);
            guard++;
        end
        chk("coincide_guard", 8'(guard < 100), 8'h01);
        step(1'b1, 1'b1, 4'hA);
        chk("code_vs_timeout", 8'(ann_state), 8'h03);
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hA);
        chk("drop_vs_code", 8'(ann_state), 8'h00);
        step(1'b0, 1'b1, 4'h3);
        chk("idle_ignores_code", 8'(ann_state), 8'h00);
        chk("idle_bad_cnt", 8'(bad_cnt), 8'h00);

        for (int i = 0; i < 2000; i++) begin
            logic       a, cv;
            logic [3:0] c;
            a  = ($urandom_range(0, 31) != 0);
            cv = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 2) == 0) ? CODE : 4'($urandom_range(0, 15));
            step(a, cv, c);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
